// File: rtl/key_collector.sv
// Assembles a 256-bit private-key candidate from a decimated random byte stream,
// with a repetition-count health test, secp256k1 range check, retries and zeroization.
module key_collector #(
  parameter int KEY_BYTES = 32,
  parameter int DECIM     = 8,
  parameter int REP_LIMIT = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic [7:0]             i_rand,
  input  logic                   i_ack,
  output logic [8*KEY_BYTES-1:0] o_key,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_error
);

  localparam int KW = 8 * KEY_BYTES;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = $clog2(KEY_BYTES + 1);
  localparam int RW = (REP_LIMIT > 0) ? $clog2(REP_LIMIT + 1) : 1;
  localparam int TW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
  localparam logic [DW-1:0] DEC_ONE   = DW'(1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(KEY_BYTES - 1);
  localparam logic [BW-1:0] BYTE_MAX  = BW'(KEY_BYTES);
  localparam logic [BW-1:0] BYTE_ONE  = BW'(1);
  localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);
  localparam logic [TW-1:0] RETRY_MAX = TW'(MAX_RETRY);
  localparam logic [TW-1:0] RETRY_ONE = TW'(1);
  localparam bit            REP_EN    = (REP_LIMIT > 0);

  localparam logic [255:0] SECP_N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dec_q;
  logic [BW-1:0]   byte_q;
  logic [RW-1:0]   rep_q;
  logic [TW-1:0]   retry_q;
  logic [KW-1:0]   key_q;

  logic            clr_all;
  logic            clr_attempt;
  logic            sample;
  logic            inc_retry;
  logic            zero_key;
  logic            rep_fail;
  logic            key_ok;

  // The group-order test only makes sense for a full 256-bit scalar.
  generate
    if (KEY_BYTES == 32) begin : g_range
      assign key_ok = (key_q != '0) && (key_q < SECP_N);
    end else begin : g_norange
      assign key_ok = 1'b1;
    end
  endgenerate

  assign rep_fail = REP_EN && (rep_q == REP_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_all     = 1'b0;
    clr_attempt = 1'b0;
    sample      = 1'b0;
    inc_retry   = 1'b0;
    zero_key    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_COLLECT;
          clr_all = 1'b1;
        end
      end
      S_COLLECT: begin
        // A stuck source aborts the attempt even if bytes are still missing.
        if (rep_fail) begin
          state_d  = S_FAIL;
          zero_key = 1'b1;
        end else if (dec_q == DEC_LAST) begin
          sample = 1'b1;
          if (byte_q == BYTE_LAST) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (rep_fail) begin
          state_d  = S_FAIL;
          zero_key = 1'b1;
        end else if (key_ok) begin
          state_d = S_DONE;
        end else if (retry_q < RETRY_MAX) begin
          state_d     = S_COLLECT;
          inc_retry   = 1'b1;
          clr_attempt = 1'b1;
        end else begin
          state_d  = S_FAIL;
          zero_key = 1'b1;
        end
      end
      S_DONE: begin
        if (i_ack) begin
          state_d  = S_IDLE;
          zero_key = 1'b1;
        end
      end
      S_FAIL: begin
        zero_key = 1'b1;
        if (i_start) begin
          state_d = S_COLLECT;
          clr_all = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        zero_key = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      dec_q   <= '0;
      byte_q  <= '0;
      rep_q   <= '0;
      retry_q <= '0;
      key_q   <= '0;
    end else if (clr_all || clr_attempt) begin
      dec_q  <= '0;
      byte_q <= '0;
      rep_q  <= '0;
      key_q  <= '0;
      if (clr_all) begin
        retry_q <= '0;
      end else if (inc_retry) begin
        retry_q <= (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_ONE;
      end
    end else if (zero_key) begin
      key_q <= '0;
    end else if (state_q == S_COLLECT) begin
      dec_q <= (dec_q == DEC_LAST) ? '0 : dec_q + DEC_ONE;
      if (sample) begin
        key_q  <= (key_q << 8) | KW'(i_rand);
        byte_q <= (byte_q == BYTE_MAX) ? byte_q : byte_q + BYTE_ONE;
        // The low key byte still holds the previous sample of this attempt.
        if (REP_EN) begin
          if (byte_q == '0) begin
            rep_q <= REP_ONE;
          end else if (i_rand == key_q[7:0]) begin
            rep_q <= (rep_q == REP_MAX) ? rep_q : rep_q + REP_ONE;
          end else begin
            rep_q <= REP_ONE;
          end
        end
      end
    end
  end

  assign o_valid = (state_q == S_DONE);
  assign o_busy  = (state_q == S_COLLECT) || (state_q == S_CHECK);
  assign o_error = (state_q == S_FAIL);
  assign o_key   = o_valid ? key_q : '0;

endmodule

// File: tb/tb_key_collector.sv
// Scoreboard bench for key_collector: stimulus pushes expected key/error events,
// a monitor pops and compares them when o_valid or o_error rises.
module tb_key_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rnd;
  logic         start_a, ack_a, start_b, ack_b;
  logic [255:0] key_a, key_b;
  logic         valid_a, busy_a, err_a;
  logic         valid_b, busy_b, err_b;

  always #5 clk = ~clk;

  key_collector dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_a), .i_rand(rnd), .i_ack(ack_a),
    .o_key(key_a), .o_valid(valid_a), .o_busy(busy_a), .o_error(err_a)
  );

  key_collector #(.REP_LIMIT(0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_b), .i_rand(rnd), .i_ack(ack_b),
    .o_key(key_b), .o_valid(valid_b), .o_busy(busy_b), .o_error(err_b)
  );

  typedef struct {
    logic         is_err;
    logic [255:0] key;
    int           cyc;
  } exp_t;

  exp_t         q_a[$];
  exp_t         q_b[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           t0 = 0;
  int           mode = 0;
  logic [7:0]   cval = 8'h00;
  logic [255:0] nom_key;
  logic         prev_v[2];
  logic         prev_e[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte for the edge that is e edges after the start edge.
  function automatic logic [7:0] gen(int e);
    int a, ep, k;
    if (e < 1) return 8'($urandom);
    a  = (e - 1) / 257;
    ep = e - 257 * a;
    if ((ep % 8) != 0 || ep > 256) return 8'($urandom);
    k = ep / 8 - 1;
    case (mode)
      1:       return cval;
      2:       return (a == 0) ? 8'hFF : (a == 1) ? 8'h00 : 8'(k + 1);
      default: return 8'(k + 1);
    endcase
  endfunction

  initial begin
    rnd = 8'h00;
    forever begin
      @(negedge clk);
      rnd = gen(cyc + 1 - t0);
    end
  end

  task automatic chk(string name, logic [255:0] act, logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic mon(bit which, logic v, logic e, logic [255:0] k);
    exp_t x;
    if (v === 1'b1 && e === 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL both_high[%0d]: valid and error together at cycle %0d", which, cyc);
    end
    if (v !== 1'b1 && k !== '0) begin
      n_vec++; n_bad++;
      $display("FAIL key_leak[%0d]: key %h while not valid", which, k);
    end
    if ((v === 1'b1 && !prev_v[which]) || (e === 1'b1 && !prev_e[which])) begin
      if ((which ? q_b.size() : q_a.size()) == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected[%0d]: valid=%0b error=%0b at cycle %0d, none expected",
                 which, v, e, cyc);
      end else begin
        x = which ? q_b.pop_front() : q_a.pop_front();
        chk($sformatf("kind[%0d]", which), 256'(e), 256'(x.is_err));
        chk($sformatf("cycle[%0d]", which), 256'(cyc), 256'(x.cyc));
        chk($sformatf("key[%0d]", which), k, x.key);
      end
    end
    prev_v[which] = (v === 1'b1);
    prev_e[which] = (e === 1'b1);
  endtask

  initial begin
    prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    prev_e[0] = 1'b0; prev_e[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mon(1'b0, valid_a, err_a, key_a);
      mon(1'b1, valid_b, err_b, key_b);
    end
  end

  task automatic start_run(bit which);
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic push(bit which, logic is_err, logic [255:0] key, int lat);
    exp_t x;
    x.is_err = is_err;
    x.key    = key;
    x.cyc    = t0 + lat;
    if (which) q_b.push_back(x); else q_a.push_back(x);
  endtask

  task automatic wait_drain(bit which, int budget);
    int n = 0;
    while ((which ? q_b.size() : q_a.size()) != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if ((which ? q_b.size() : q_a.size()) != 0) begin
      n_vec++; n_bad++;
      $display("FAIL timeout[%0d]: %0d events still pending after %0d cycles",
               which, which ? q_b.size() : q_a.size(), budget);
      if (which) q_b.delete(); else q_a.delete();
    end
  endtask

  task automatic ack_run(bit which);
    @(negedge clk);
    if (which) ack_b = 1'b1; else ack_a = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("ack_valid[%0d]", which), 256'(which ? valid_b : valid_a), 256'(0));
    chk($sformatf("ack_key[%0d]", which), which ? key_b : key_a, 256'(0));
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  initial begin
    nom_key = '0;
    for (int k = 0; k < 32; k++) nom_key = {nom_key[247:0], 8'(k + 1)};
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;

    // Reset with start held high and random bytes
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_a", key_a, 256'(0));
    chk("rst_valid_a", 256'(valid_a), 256'(0));
    chk("rst_busy_a", 256'(busy_a), 256'(0));
    chk("rst_error_a", 256'(err_a), 256'(0));
    chk("rst_outs_b", {key_b[252:0], valid_b, busy_b, err_b}, 256'(0));
    @(negedge clk);
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(posedge clk);

    // Nominal key, acknowledged one cycle after valid
    mode = 0;
    start_run(1'b0);
    chk("busy_at_t0", 256'(busy_a), 256'(1));
    push(1'b0, 1'b0, nom_key, 257);
    repeat (257) @(posedge clk);
    #2;
    chk("nom_busy_low", 256'(busy_a), 256'(0));
    ack_run(1'b0);
    wait_drain(1'b0, 4);

    // Stuck source trips the repetition test
    mode = 1; cval = 8'hA5;
    start_run(1'b0);
    push(1'b0, 1'b1, 256'(0), 33);
    repeat (33) @(posedge clk);
    #2;
    chk("rep_busy", 256'(busy_a), 256'(0));
    chk("rep_error", 256'(err_a), 256'(1));
    wait_drain(1'b0, 4);
    mode = 0;
    start_run(1'b0);
    chk("restart_error", 256'(err_a), 256'(0));
    push(1'b0, 1'b0, nom_key, 257);
    wait_drain(1'b0, 300);
    ack_run(1'b0);

    // Two out-of-range attempts, third accepted
    mode = 2;
    start_run(1'b1);
    push(1'b1, 1'b0, nom_key, 3 * 257);
    wait_drain(1'b1, 800);
    ack_run(1'b1);

    // Every attempt out of range exhausts the retries
    mode = 1; cval = 8'hFF;
    start_run(1'b1);
    push(1'b1, 1'b1, 256'(0), 4 * 257);
    wait_drain(1'b1, 1100);
    chk("exh_error", 256'(err_b), 256'(1));

    // Ignored start and ack during collection
    mode = 0;
    start_run(1'b0);
    push(1'b0, 1'b0, nom_key, 257);
    repeat (49) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (49) @(posedge clk);
    @(negedge clk);
    ack_a = 1'b1;
    @(posedge clk);
    #1;
    ack_a = 1'b0;
    chk("dist_busy", 256'(busy_a), 256'(1));
    wait_drain(1'b0, 200);
    ack_run(1'b0);

    // Reset in the middle of collection discards the attempt
    start_run(1'b0);
    repeat (119) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_key", key_a, 256'(0));
    chk("mid_rst_flags", {valid_a, busy_a, err_a}, 256'(0));
    chk("mid_rst_b_err", 256'(err_b), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_run(1'b0);
    push(1'b0, 1'b0, nom_key, 257);
    wait_drain(1'b0, 300);
    ack_run(1'b0);

    repeat (5) @(posedge clk);
    #2;
    chk("queue_a_empty", 256'(q_a.size()), 256'(0));
    chk("queue_b_empty", 256'(q_b.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_collector.md
# key_collector

Consumes the byte stream of the wallet's LFSR random-byte generator and assembles it into a 256-bit private-key candidate. It decimates the stream so that each sampled byte is made of fully shifted bits, and runs a repetition-count health test on every sample. It then range-checks the candidate against the secp256k1 group order and retries on an out-of-range key. The result is delivered to the signing logic through a valid/ack handshake, and the key is zeroized once it has been consumed.

## Interface
- KEY_BYTES, 32: number of bytes per key; the range check applies only when KEY_BYTES=32.
- DECIM, 8: clock cycles between samples; must be at least 1.
- REP_LIMIT, 4: number of identical consecutive samples that declares failure; 0 disables the test.
- MAX_RETRY, 3: number of range-check retries allowed before failure.
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_start  in  1  request a new key; sampled in IDLE and FAIL only.
- i_rand  in  8  random byte from the generator; changes every cycle.
- i_ack  in  1  consumer has taken the key; sampled in DONE only.
- o_key  out  8*KEY_BYTES  key; forced to 0 whenever o_valid=0.
- o_valid  out  1  key available; held until acknowledged.
- o_busy  out  1  high in COLLECT and CHECK.
- o_error  out  1  high in FAIL.

## Operation
- States:
  - IDLE: i_start → COLLECT. Clear the byte counter, decimation counter, repetition counter and retry counter.
  - COLLECT: the decimation counter runs 0..DECIM-1 and wraps. At the edge where it equals DECIM-1, sample i_rand:
    - shift the key register left 8 bits and load the sample into the low byte, so the first sample ends up in the MSB byte;
    - increment the byte counter.
  - COLLECT → CHECK: on the KEY_BYTES-th sample.
  - CHECK lasts one cycle. The key is valid when key≠0 and key<n, with n=FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141.
    - Valid → DONE.
    - Invalid and retry counter < MAX_RETRY → increment the retry counter, then COLLECT. Clear the byte, decimation and repetition counters and the key register.
    - Invalid and retries exhausted → FAIL.
  - DONE: i_ack=1 → IDLE, and the key register is zeroized.
  - FAIL: the key register is zeroized. i_start → COLLECT with all counters cleared, and o_error falls.
- Repetition test (REP_LIMIT>0):
  - The first sample of each attempt sets the count to 1.
  - Each later sample equal to the previous sample increments the count; a different sample resets it to 1.
  - When the count reaches REP_LIMIT on a sample edge, the next state is FAIL, regardless of the byte count.
- Ignored inputs:
  - i_start in COLLECT, CHECK and DONE.
  - i_ack outside DONE.
- All counters saturate at their terminal values and never wrap past them.

## Timing
- Reset value of every output is 0. State is IDLE and all internal registers, including the key, are 0.
- Reset asserted in any state, including mid-COLLECT and DONE, returns the block to IDLE on that edge. The partial key is discarded.
- Let t0 be the edge at which i_start is sampled in IDLE.
  - Samples are taken at edges t0+DECIM·k, for k=1..KEY_BYTES.
  - CHECK is entered at t0+DECIM·KEY_BYTES.
  - o_valid is high from edge t0+DECIM·KEY_BYTES+1; for the defaults that is t0+257.
- Each retry adds DECIM·KEY_BYTES+1 cycles to the latency.
- o_busy rises at t0 and falls at the same edge as o_valid or o_error rises.
- Acknowledge: with i_ack high at edge t, o_valid and o_key are 0 after edge t. A new i_start is accepted from edge t+1.
- o_valid and o_error are never high at the same time.

## Test plan
- Reset: hold i_reset_n=0 for 3 cycles with random i_rand and i_start=1 → o_key=0, o_valid=0, o_busy=0, o_error=0.
- Nominal (defaults): drive i_rand=k+1 during the sample window for sample k (k=0..31), then start → o_key=0x0102…1F20 and o_valid=1 at t0+257. Assert i_ack one cycle later → o_valid=0 and o_key=0 on the next cycle.
- Repetition fail: i_rand constant 0xA5, start → o_error=1 and o_busy=0 at t0+33, o_key=0. Assert i_start again with changing bytes → o_error=0 and the block collects normally.
- Range retry (REP_LIMIT=0): attempt 1 all 0xFF, attempt 2 all 0x00, attempt 3 bytes 0x01..0x20 → o_valid at t0+3·257. The key equals the attempt-3 value.
- Retry exhaustion (REP_LIMIT=0): i_rand constant 0xFF → o_error=1 at t0+4·257, and o_valid never rises.
- Disturbances: pulse i_start at t0+50 and i_ack at t0+100 → no effect, o_valid at t0+257. Then reset at t0'+120 of a second run → IDLE with all outputs 0. A subsequent start completes at the nominal latency.
